packet_com_arbiter: RTL
=======================

// Module: packet_com_arbiter
// PURPOSE
//   Shares one packet_com serial link between N_REQ byte producers (raw TRNG stream, health-test
//   status, debug). Grants whole packets round-robin, prefixes each packet with a 1-byte channel
//   header, and forwards payload bytes to packet_com. Sits directly in front of packet_com.
//   Pads a packet with 0x00 if the granted producer stalls past a timeout.
// PARAMETERS
//   N_REQ        4      number of requesters (2..16)
//   HDR_TAG      4'hA   upper nibble of header byte; header = {HDR_TAG, 4'(channel index)}
//   TIMEOUT_CYC  4096   idle cycles in DATA before abort-and-pad (>=1)
// PORTS
//   i_clk            in   1         system clock
//   i_reset_n        in   1         asynchronous active-low reset
//   i_req            in   N_REQ     requester i has a packet pending (level)
//   i_size           in   7*N_REQ   payload bytes of requester i, slice [7*i+:7]
//   i_dat            in   8*N_REQ   payload byte of requester i, slice [8*i+:8]
//   i_write          in   N_REQ     requester i writes i_dat slice (valid only while o_ready[i])
//   o_grant          out  N_REQ     one-hot, requester owns the link (START..DRAIN)
//   o_ready          out  N_REQ     requester may write this cycle
//   o_done           out  N_REQ     1-cycle pulse when requester's packet leaves DRAIN
//   o_abort          out  1         1-cycle pulse when timeout padding starts
//   o_start_packet   out  1         to packet_com i_start_packet
//   o_packet_size    out  7         to packet_com i_packet_size (payload + 1 header byte)
//   o_dat            out  8         to packet_com i_dat
//   o_write          out  1         to packet_com i_write
//   i_com_ready      in   1         from packet_com o_ready
//   i_packet_ongoing in   1         from packet_com o_packet_ongoing
// BEHAVIOUR
//   Reset: state IDLE, rr pointer=N_REQ-1, all outputs 0, remaining=0, timer=0.
//   IDLE: if any i_req, pick first set index after rr pointer (wrapping); latch index, latch
//     size (127 clamped to 126; 0 allowed = header-only packet); set o_grant; -> START. No req: stay.
//   START: o_start_packet=1 for exactly one cycle, o_packet_size=latched size+1; -> HDR.
//   HDR: when i_com_ready: o_write=1, o_dat=header byte; -> DATA (size>0) else -> DRAIN.
//   DATA: o_ready[g]=i_com_ready & (remaining>0); o_write=i_write[g]&o_ready[g]; o_dat=i_dat[g]
//     (combinational pass-through, zero latency). Each write decrements remaining, clears timer.
//     Writes from non-granted requesters or with o_ready low are ignored. remaining==0 -> DRAIN.
//     timer reaches TIMEOUT_CYC with no write -> o_abort pulse, -> PAD.
//   PAD: o_ready[g]=0; arbiter writes 0x00 on each i_com_ready cycle until remaining==0 -> DRAIN.
//   DRAIN: wait for i_packet_ongoing==0 (packet_com has padded frame and seen new frame);
//     then o_done[g] pulse, rr pointer<=g, o_grant<=0, -> IDLE. Next grant earliest 1 cycle later.
//   i_req dropping after grant does not abort the packet; o_write never asserts outside HDR/DATA/PAD.
//   At most one o_write per cycle; o_write only when i_com_ready=1.
//   Reset mid-packet: immediate return to IDLE; packet_com shares reset so no half packet persists.
// STRUCTURE
//   trng_com_defs.vh: state encodings (IDLE,START,HDR,DATA,PAD,DRAIN), HDR_TAG default,
//     MAX_PAYLOAD=126, shared with packet_com users.
//   Sub-module rr_arbiter (N_REQ req, last-grant pointer in -> one-hot grant + index out), combinational.
//   Top holds FSM, remaining counter (7b), timeout counter ($clog2(TIMEOUT_CYC+1) bits), muxes.
// TESTING (bench uses real packet_com+trng_com+tx, RTS asserted, UART monitor decodes bytes)
//   Req0 size=3 bytes 11,22,33 -> start_packet size=4; link carries A0,11,22,33 then 0x00 pad; o_done[0].
//   Req1 and req3 held high together, pointer=0 -> grant 1 then 3 then 1; headers A1,A3,A1.
//   Req2 size=5, stops after 2 bytes, TIMEOUT_CYC=16 -> o_abort at 16 idle cycles, 3x 0x00 sent, o_done[2].
//   Req0 size=0 -> single header byte A0, no o_ready[0] ever; size=127 -> o_packet_size=127 (clamped).
//   i_write from non-granted req2 during req0 DATA -> no extra byte, remaining unchanged.
//   i_reset_n low mid-DATA -> outputs 0 asynchronously; after release next req granted from pointer N_REQ-1.

Source files
------------

// File: rtl/packet_com_arbiter_pkg.sv
// Shared definitions for the packet_com arbiter: FSM encodings, header tag and
// payload limits used by the arbiter and anything feeding packet_com.
package packet_com_arbiter_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_HDR   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_PAD   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;
  localparam logic [6:0] MAX_PAYLOAD     = 7'd126;

  // 127 payload bytes plus the header would overflow packet_com's 7-bit size.
  function automatic logic [6:0] clamp_size(input logic [6:0] size);
    return (size == 7'd127) ? MAX_PAYLOAD : size;
  endfunction

endpackage

// File: rtl/packet_com_arbiter_if.sv
// Producer-side and packet_com-side signals of the arbiter, seen from the arbiter
// (master) or from the producers/link (slave).
interface packet_com_arbiter_if #(
  parameter int N_REQ = 4
);
  // Producer handshake: a byte moves on a cycle where i_write[i] & o_ready[i] are
  // both high at the clock edge. Link handshake: a byte moves on every o_write,
  // and o_write is only raised while i_com_ready is high.
  logic [N_REQ-1:0]   i_req;
  logic [7*N_REQ-1:0] i_size;
  logic [8*N_REQ-1:0] i_dat;
  logic [N_REQ-1:0]   i_write;
  logic [N_REQ-1:0]   o_grant;
  logic [N_REQ-1:0]   o_ready;
  logic [N_REQ-1:0]   o_done;
  logic               o_abort;
  logic               o_start_packet;
  logic [6:0]         o_packet_size;
  logic [7:0]         o_dat;
  logic               o_write;
  logic               i_com_ready;
  logic               i_packet_ongoing;

  modport master (
    input  i_req, i_size, i_dat, i_write, i_com_ready, i_packet_ongoing,
    output o_grant, o_ready, o_done, o_abort, o_start_packet, o_packet_size,
           o_dat, o_write
  );

  modport slave (
    output i_req, i_size, i_dat, i_write, i_com_ready, i_packet_ongoing,
    input  o_grant, o_ready, o_done, o_abort, o_start_packet, o_packet_size,
           o_dat, o_write
  );

endinterface

// File: rtl/packet_com_arbiter_rr.sv
// Combinational round-robin pick: first requester strictly after the last-grant
// pointer, wrapping, so the last owner has lowest priority.
module packet_com_arbiter_rr #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  localparam logic [IW:0] NR = (IW+1)'(N_REQ);

  logic [IW:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_j = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_j >= NR) w_j = w_j - NR;
      if (!o_any && i_req[w_j[IW-1:0]]) begin
        o_any                 = 1'b1;
        o_grant[w_j[IW-1:0]]  = 1'b1;
        o_idx                 = w_j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/packet_com_arbiter.sv
// Shares one packet_com link between N_REQ producers: whole-packet round-robin,
// 1-byte channel header, zero padding when the owner stalls past TIMEOUT_CYC.
module packet_com_arbiter
  import packet_com_arbiter_pkg::*;
#(
  parameter int         N_REQ       = 4,
  parameter logic [3:0] HDR_TAG     = HDR_TAG_DEFAULT,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  packet_com_arbiter_if.master bus,
  output logic [2:0]          o_dbg_state
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_ptr;
  logic [N_REQ-1:0] r_grant;
  logic [6:0]       r_size;
  logic [6:0]       r_rem;
  logic [TW-1:0]    r_timer;

  logic [N_REQ-1:0] w_arb_grant;
  logic [IW-1:0]    w_arb_idx;
  logic             w_arb_any;
  logic [6:0]       w_new_size;
  logic [7:0]       w_g_dat;
  logic             w_g_write;
  logic             w_data_rdy;
  logic             w_data_wr;
  logic             w_pad_wr;
  logic             w_hdr_wr;
  logic             w_timeout;
  logic             w_drain_done;

  packet_com_arbiter_rr #(.N_REQ(N_REQ)) u_rr (
    .i_req   (bus.i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  // Slice selection written as explicit muxes to keep index arithmetic narrow.
  always_comb begin
    w_new_size = '0;
    w_g_dat    = '0;
    w_g_write  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_idx == IW'(i)) w_new_size = clamp_size(bus.i_size[7*i +: 7]);
      if (r_idx == IW'(i)) begin
        w_g_dat   = bus.i_dat[8*i +: 8];
        w_g_write = bus.i_write[i];
      end
    end
  end

  always_comb begin
    w_data_rdy   = (r_state == ST_DATA) && bus.i_com_ready && (r_rem != 7'd0);
    w_data_wr    = w_data_rdy && w_g_write;
    w_pad_wr     = (r_state == ST_PAD) && bus.i_com_ready && (r_rem != 7'd0);
    w_hdr_wr     = (r_state == ST_HDR) && bus.i_com_ready;
    w_timeout    = (r_state == ST_DATA) && !w_data_wr && (r_rem != 7'd0) &&
                   (r_timer == TW'(TIMEOUT_CYC - 1));
    w_drain_done = (r_state == ST_DRAIN) && !bus.i_packet_ongoing;

    bus.o_grant        = r_grant;
    bus.o_ready        = w_data_rdy ? r_grant : '0;
    bus.o_done         = w_drain_done ? r_grant : '0;
    bus.o_abort        = w_timeout;
    bus.o_start_packet = (r_state == ST_START);
    bus.o_packet_size  = (r_state == ST_START) ? (r_size + 7'd1) : 7'd0;
    bus.o_write        = w_hdr_wr || w_data_wr || w_pad_wr;
    bus.o_dat          = 8'h00;
    if (r_state == ST_HDR)       bus.o_dat = {HDR_TAG, 4'(r_idx)};
    else if (r_state == ST_DATA) bus.o_dat = w_g_dat;
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ptr   <= IW'(N_REQ - 1);
      r_grant <= '0;
      r_size  <= '0;
      r_rem   <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            r_idx   <= w_arb_idx;
            r_grant <= w_arb_grant;
            r_size  <= w_new_size;
            r_rem   <= w_new_size;
            r_timer <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: r_state <= ST_HDR;
        ST_HDR: begin
          if (bus.i_com_ready) r_state <= (r_rem != 7'd0) ? ST_DATA : ST_DRAIN;
        end
        ST_DATA: begin
          if (w_data_wr) begin
            r_rem   <= r_rem - 7'd1;
            r_timer <= '0;
            if (r_rem == 7'd1) r_state <= ST_DRAIN;
          end else if (r_rem == 7'd0) begin
            r_state <= ST_DRAIN;
          end else if (w_timeout) begin
            r_state <= ST_PAD;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_PAD: begin
          if (w_pad_wr) begin
            r_rem <= r_rem - 7'd1;
            if (r_rem == 7'd1) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_ptr   <= r_idx;
            r_grant <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
